// File: rtl/led_blink_seq_ctrl_if.sv
// Command handshake bundle for the LED blink sequencer.
// The master (PS/GPIO side) drives cmd_valid/cmd_count and must hold both
// until it sees cmd_valid & cmd_ready on a rising clock edge.
interface led_blink_seq_ctrl_if #(
    parameter int NUM_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [NUM_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/led_blink_seq_ctrl.sv
// LED blink sequencer.
// Accepts a pulse-count command, then drives an active-high pulse train on
// led_drive: PRESCALE enabled cycles ON, PRESCALE enabled cycles OFF, repeated
// cmd_count times, followed by a one-cycle done pulse.
// en=0 freezes the timing only; abort returns to IDLE silently.
// Optional build macro: LED_BLINK_HEARTBEAT_EN adds a slow idle heartbeat on
// led_drive (toggles every 2*PRESCALE enabled cycles while IDLE).
module led_blink_seq_ctrl #(
    parameter int PRESCALE = 25000000,
    parameter int CNT_W    = 25,
    parameter int NUM_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 abort,
    led_blink_seq_ctrl_if.slave  cmd_if,
    output logic                 led_drive,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] PS_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ZERO = {NUM_W{1'b0}};
    localparam logic [NUM_W-1:0] NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_W-1:0] pcnt_q, pcnt_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rdy_q, rdy_d;

    logic             accept_s;
    logic             ps_last_s;
    logic             hb_led_s;

    // cmd_ready is the registered "will be idle" flag, masked combinationally by abort
    assign cmd_if.cmd_ready = rdy_q & ~abort;
    assign accept_s         = cmd_if.cmd_valid & cmd_if.cmd_ready;
    assign ps_last_s        = (cnt_q == PS_LAST);

    assign led_drive = led_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter update; abort outranks en and phase ends
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_d = CNT_ZERO;
                    if (cmd_if.cmd_count != NUM_ZERO) begin
                        state_d = ST_ON;
                        pcnt_d  = cmd_if.cmd_count;
                    end else begin
                        state_d = ST_DONE;
                        pcnt_d  = NUM_ZERO;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ON: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    pcnt_d  = NUM_ZERO;
                end else if (en) begin
                    if (ps_last_s) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_OFF;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_OFF: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    pcnt_d  = NUM_ZERO;
                end else if (en) begin
                    if (ps_last_s) begin
                        cnt_d  = CNT_ZERO;
                        pcnt_d = pcnt_q - NUM_ONE;
                        // Last pulse finished when the count we are leaving is one
                        if (pcnt_q == NUM_ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ON;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_DONE: begin
                // Leaves after one cycle regardless of en or abort
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                pcnt_d  = NUM_ZERO;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                pcnt_d  = NUM_ZERO;
            end
        endcase
    end

    // Output decode from the next state so every output is a clean flop
    always_comb begin
        led_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        rdy_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                led_d = hb_led_s;
                rdy_d = 1'b1;
            end
            ST_ON: begin
                led_d  = 1'b1;
                busy_d = 1'b1;
            end
            ST_OFF: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                led_d  = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b0;
                rdy_d  = 1'b0;
            end
        endcase
    end

    // Counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= CNT_ZERO;
            pcnt_q <= NUM_ZERO;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pcnt_q <= pcnt_d;
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rdy_q  <= rdy_d;
        end
    end

`ifdef LED_BLINK_HEARTBEAT_EN
    localparam int            HB_W    = CNT_W + 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(2 * PRESCALE - 1);
    localparam logic [HB_W-1:0] HB_ZERO = {HB_W{1'b0}};
    localparam logic [HB_W-1:0] HB_ONE  = {{(HB_W-1){1'b0}}, 1'b1};

    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            hb_ph_q, hb_ph_d;

    // Heartbeat runs only while staying in IDLE; anything else restarts it dark
    always_comb begin
        hb_cnt_d = hb_cnt_q;
        hb_ph_d  = hb_ph_q;
        if ((state_q == ST_IDLE) && !abort && !accept_s) begin
            if (en) begin
                if (hb_cnt_q == HB_LAST) begin
                    hb_cnt_d = HB_ZERO;
                    hb_ph_d  = ~hb_ph_q;
                end else begin
                    hb_cnt_d = hb_cnt_q + HB_ONE;
                end
            end else begin
                hb_cnt_d = hb_cnt_q;
                hb_ph_d  = hb_ph_q;
            end
        end else begin
            hb_cnt_d = HB_ZERO;
            hb_ph_d  = 1'b0;
        end
    end

    // Heartbeat registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt_q <= HB_ZERO;
            hb_ph_q  <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_ph_q  <= hb_ph_d;
        end
    end

    assign hb_led_s = hb_ph_d;
`else
    assign hb_led_s = 1'b0;
`endif

endmodule

// File: doc/led_blink_seq_ctrl.md
Name: led_blink_seq_ctrl

Overview:
- Sequencer for the board LED output path. Accepts blink commands from the PS/GPIO side through a valid/ready handshake.
- Generates an active-high timed pulse train, `led_drive`. This feeds the existing inverter stage that drives the active-low LED pin.
- Owns all LED timing: prescaling, pulse counting, pause, abort and completion signalling.

Parameters:
- PRESCALE, 25000000, clock cycles per ON phase and per OFF phase (0.5 s at 50 MHz); must be >= 2.
- CNT_W, 25, prescale counter width; must hold PRESCALE-1.
- NUM_W, 8, width of the pulse-count command field.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; 0 freezes the sequencer.
- abort  in  1  synchronous abort of the current sequence.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_count  in  NUM_W  number of ON/OFF pulses requested.
- led_drive  out  1  active-high LED request to the inverter stage.
- busy  out  1  high in ON or OFF.
- done  out  1  one-cycle pulse when a sequence completes normally.

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset `rst` is asynchronous and active-high.
  - While `rst` is high: state=IDLE, prescale counter=0, pulse counter=0, led_drive=0, busy=0, done=0, cmd_ready=0.
  - After `rst` deasserts, cmd_ready=1 from the first clock edge onward (registered).
- States: IDLE, ON, OFF, DONE. All outputs are registered or decoded from state.
- cmd_ready = (state==IDLE) & ~abort.
  - A command is accepted on an edge where cmd_valid & cmd_ready.
  - cmd_count is captured on that edge only.
- IDLE, on accept with cmd_count>0: next state ON, prescale counter=0, pulse counter=cmd_count. led_drive=1 from the next cycle (1-cycle latency).
- IDLE, on accept with cmd_count==0: next state DONE. led_drive stays 0; done=1 on the next cycle.
- ON phase:
  - led_drive=1, busy=1. The counter increments each enabled cycle.
  - At PRESCALE-1: counter=0, go to OFF.
  - ON lasts exactly PRESCALE enabled cycles.
- OFF phase:
  - led_drive=0, busy=1. At PRESCALE-1: counter=0 and the pulse counter decrements.
  - If the decremented value is 0, go to DONE; otherwise go to ON.
- DONE: done=1, busy=0, led_drive=0, cmd_ready=0 for exactly one cycle, then IDLE.
  - Total sequence = 2*PRESCALE*N cycles, then done. A command held valid is accepted on the cycle after DONE.
- en=0:
  - State, prescale counter and pulse counter hold, and led_drive holds its level.
  - The DONE->IDLE transition and IDLE command acceptance still occur (en gates timing only).
- abort=1 in ON/OFF/DONE: next cycle IDLE, counters=0, led_drive=0, busy=0, no done pulse.
  - abort has priority over en and over phase transitions.
- abort=1 in IDLE: no state change, and cmd_ready is forced to 0, so no command is accepted that cycle.
- cmd_valid while not ready: ignored, with no side effects. Upstream must hold cmd_valid/cmd_count until accepted.
- cmd_count=2^NUM_W-1 (255): 255 full pulses; the counter never wraps.
- rst asserted mid-sequence: immediate return to reset values, with no done pulse.

Optional Feature:
- Macro LED_BLINK_HEARTBEAT_EN.
- Defined:
  - In IDLE (en=1), led_drive toggles every 2*PRESCALE cycles, driven by a separate heartbeat counter and phase bit.
  - The counter and phase clear on command accept, abort and reset. On leaving DONE, the heartbeat starts from led_drive=0 with the counter at 0.
  - en=0 freezes the heartbeat.
- Not defined: led_drive=0 in IDLE, and no heartbeat logic is instantiated.
- Both builds: the ON/OFF sequence timing is identical.

Test Plan (PRESCALE=4, macro undefined unless stated):
- Reset, then cmd_valid=1, cmd_count=3 accepted at edge T:
  - led_drive=1 on T+1..T+4, 0 on T+5..T+8, repeated 3x through T+24.
  - done=1 only at T+25; cmd_ready=1 at T+26.
- cmd_count=0 accepted at T: led_drive stays 0, busy stays 0, done=1 at T+1, cmd_ready=1 at T+2.
- cmd_count=3 with en=0 for 10 cycles starting T+6:
  - led_drive holds 0 during the pause.
  - done shifts to T+35; total led_drive-high cycles = 12.
- abort=1 at T+3 during ON: led_drive=0, busy=0, cmd_ready=1 at T+4, no done ever.
  - Also: abort=1 together with cmd_valid in IDLE -> command not accepted that cycle; accepted on the next edge after abort drops.
- rst pulsed asynchronously at T+10 (between edges): led_drive, busy, done, cmd_ready = 0 immediately; IDLE after release.
- LED_BLINK_HEARTBEAT_EN defined, idle from reset:
  - led_drive toggles every 8 cycles.
  - A command accepted mid-heartbeat gives led_drive=1 at T+1 and normal sequence timing.
